// File: rtl/qspi_nibble_if.sv
// Quad-SPI nibble master: cmd/addr/dummy/data transactions, nibble-wide read return.
// Define QSPI_WRITE_EN to build the quad write path.
module qspi_nibble_if #(
  parameter logic [7:0] READ_CMD     = 8'hEB,
  parameter logic [7:0] WRITE_CMD    = 8'h38,
  parameter int         DUMMY_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        ready,
  input  logic        wr,
  input  logic [23:0] spiAddrOut,
  input  logic [1:0]  memType,
  input  logic [31:0] wdata,
  output logic [3:0]  memDataIn,
  output logic [2:0]  dataPosIn,
  output logic        memClk,
  output logic        memReady,
  output logic        sck,
  output logic        cs_n,
  output logic [3:0]  io_out,
  output logic        io_oe,
  input  logic [3:0]  io_in
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_REC   = 3'd6;

  localparam logic [3:0] DLAST = 4'(DUMMY_CYCLES - 1);
  localparam bit HAS_DUMMY = (DUMMY_CYCLES != 0);

  logic [2:0]  st;
  logic        ph;
  logic [3:0]  cnt;
  logic [31:0] hdr;
  logic        wrq;
  logic [1:0]  mt;
  logic [2:0]  k;
  logic [2:0]  nlast;
  logic        busy;
  logic        hdr_oe;
  logic        wdrive;
  logic [3:0]  wnib;
  logic        skip;

  assign k     = cnt[2:0];
  assign nlast = {mt == 2'b11, mt[1], 1'b1};

`ifdef QSPI_WRITE_EN
  logic [31:0] wdat;

  always_ff @(posedge clk) begin
    if (!rst)
      wdat <= '0;
    else if (st == S_IDLE && req)
      wdat <= wdata;
  end

  // byte k>>1, high nibble on even k
  assign wnib   = wdat[{k[2:1], ~k[0], 2'b00} +: 4];
  assign wdrive = (st == S_DATA) && wrq;
  assign skip   = (memType == 2'b00);
`else
  logic unused_wdata;

  assign unused_wdata = ^wdata;
  assign wnib   = 4'h0;
  assign wdrive = 1'b0;
  assign skip   = (memType == 2'b00) || wr;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= S_IDLE;
      ph        <= 1'b0;
      cnt       <= '0;
      hdr       <= '0;
      wrq       <= 1'b0;
      mt        <= '0;
      memDataIn <= '0;
      dataPosIn <= '0;
      memClk    <= 1'b0;
    end else begin
      memClk <= 1'b0;
      case (st)
        S_IDLE: begin
          if (req) begin
            wrq <= wr;
            mt  <= memType;
            hdr <= {wr ? WRITE_CMD : READ_CMD, spiAddrOut};
            ph  <= 1'b0;
            cnt <= '0;
            st  <= skip ? S_DONE : S_CMD;
          end
        end
        S_DONE: st <= S_REC;
        S_REC:  st <= S_IDLE;
        default: begin
          if (!ph) begin
            ph <= 1'b1;
            if (st == S_DATA && !wrq) begin
              memDataIn <= io_in;
              dataPosIn <= {~k[0], k[2:1]};
              memClk    <= 1'b1;
            end
          end else begin
            ph  <= 1'b0;
            cnt <= cnt + 4'd1;
            hdr <= {hdr[27:0], 4'h0};
            case (st)
              S_CMD: begin
                if (cnt == 4'd1) begin
                  cnt <= '0;
                  st  <= S_ADDR;
                end
              end
              S_ADDR: begin
                if (cnt == 4'd5) begin
                  cnt <= '0;
                  st  <= (wrq || !HAS_DUMMY) ? S_DATA : S_DUMMY;
                end
              end
              S_DUMMY: begin
                if (cnt == DLAST) begin
                  cnt <= '0;
                  st  <= S_DATA;
                end
              end
              S_DATA: begin
                if (k == nlast)
                  st <= S_DONE;
              end
              default: st <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign busy     = (st == S_CMD) || (st == S_ADDR) ||
                    (st == S_DUMMY) || (st == S_DATA);
  assign hdr_oe   = (st == S_CMD) || (st == S_ADDR);
  assign ready    = (st == S_IDLE);
  assign memReady = (st == S_DONE);
  assign cs_n     = !busy;
  assign sck      = busy && ph;
  assign io_oe    = hdr_oe || wdrive;
  assign io_out   = hdr_oe ? hdr[31:28] : (wdrive ? wnib : 4'h0);

endmodule

// File: tb/tb_qspi_nibble_if.sv
// Self-checking bench for qspi_nibble_if with a QSPI device model.
// Exercises reads, writes (or their no-op form), no-op, reset and back-to-back.
module tb_qspi_nibble_if;

  localparam int D = 6;

  logic        clk;
  logic        rst;
  logic        req;
  logic        ready;
  logic        wr;
  logic [23:0] spiAddrOut;
  logic [1:0]  memType;
  logic [31:0] wdata;
  logic [3:0]  memDataIn;
  logic [2:0]  dataPosIn;
  logic        memClk;
  logic        memReady;
  logic        sck;
  logic        cs_n;
  logic [3:0]  io_out;
  logic        io_oe;
  logic [3:0]  io_in;

  qspi_nibble_if dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .wr(wr),
    .spiAddrOut(spiAddrOut), .memType(memType), .wdata(wdata),
    .memDataIn(memDataIn), .dataPosIn(dataPosIn), .memClk(memClk),
    .memReady(memReady), .sck(sck), .cs_n(cs_n), .io_out(io_out),
    .io_oe(io_oe), .io_in(io_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] devWord;
  int devSkip;
  int nib;

  // device: presents data nibble during SCK low, counts SCK periods
  always @(posedge clk) begin
    int j;
    #1;
    if (cs_n) nib = 0;
    else if (!sck) begin
      j = nib - devSkip;
      if (j >= 0 && j < 8)
        io_in = devWord[(j / 2) * 8 + ((j % 2 == 0) ? 4 : 0) +: 4];
      else
        io_in = 4'($urandom);
    end else nib = nib + 1;
  end

  logic [6:0] strobes[$];
  logic [4:0] outs[$];
  int lat;
  int lastStb;
  int csLow;

  function automatic int nibs(input logic [1:0] t);
    return (t == 2'b01) ? 2 : (t == 2'b10) ? 4 : (t == 2'b11) ? 8 : 0;
  endfunction

  task automatic xact(input logic w, input logic [23:0] a,
                      input logic [1:0] t, input logic [31:0] d);
    strobes.delete();
    outs.delete();
    lat = -1;
    lastStb = -1;
    csLow = 0;
    for (int i = 0; i < 50 && !ready; i++) @(posedge clk) #1;
    req = 1'b1; wr = w; spiAddrOut = a; memType = t; wdata = d;
    @(posedge clk) #1;
    req = 1'b0;
    wr = 1'($urandom);
    spiAddrOut = 24'($urandom);
    memType = 2'($urandom);
    wdata = $urandom;
    for (int c = 1; c <= 300; c++) begin
      if (memClk) begin
        strobes.push_back({dataPosIn, memDataIn});
        lastStb = c;
      end
      if (sck) outs.push_back({io_oe, io_out});
      if (!cs_n) csLow++;
      if (memReady) begin
        lat = c;
        break;
      end
      @(posedge clk) #1;
    end
  endtask

  task automatic test_reset();
    logic [15:0] rv;
    logic [15:0] rexp;
    int bad;
    rexp = {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 1'b0};
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rv = {ready, cs_n, sck, io_oe, io_out, memDataIn, dataPosIn, memClk, memReady};
    checks++;
    if (rv !== rexp) begin
      errors++;
      $display("FAIL reset_init got %h exp %h", rv, rexp);
    end
    rst = 1'b1;
    @(posedge clk) #1;
    devWord = 32'hFFFF_FFFF;
    devSkip = 8 + D;
    req = 1'b1; wr = 1'b0; memType = 2'b11; spiAddrOut = 24'h000100;
    @(posedge clk) #1;
    req = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      rv = {ready, cs_n, sck, io_oe, io_out, memDataIn, dataPosIn, memClk, memReady};
      checks++;
      if (rv !== rexp) begin
        errors++;
        $display("FAIL reset_mid cyc %0d got %h exp %h", i, rv, rexp);
      end
    end
    rst = 1'b1;
    @(posedge clk) #1;
    checks++;
    if ({ready, cs_n} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release got %b exp 11", {ready, cs_n});
    end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (memReady || memClk || !cs_n) bad++;
      @(posedge clk) #1;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_quiet got %0d events exp 0", bad);
    end
  endtask

  task automatic test_reads();
    logic [23:0] a;
    logic [1:0]  t;
    logic [31:0] d;
    logic [31:0] h;
    logic [31:0] got;
    logic [31:0] mask;
    logic [2:0]  pn;
    logic [6:0]  es;
    int n;
    int hbad;
    int sbad;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        a = 24'h00_0010; t = 2'b11; d = 32'h1234_5678;
      end else if (i == 1) begin
        a = 24'($urandom); t = 2'b01; d = {24'($urandom), 8'hA5};
      end else begin
        a = 24'($urandom); t = 2'($urandom_range(1, 3)); d = $urandom;
      end
      devWord = d;
      devSkip = 8 + D;
      n = nibs(t);
      xact(1'b0, a, t, $urandom);
      checks++;
      if (lat !== 2 * (8 + D + n) + 1) begin
        errors++;
        $display("FAIL rd_latency #%0d got %0d exp %0d", i, lat, 2 * (8 + D + n) + 1);
      end
      checks++;
      if (lastStb !== lat - 1) begin
        errors++;
        $display("FAIL rd_last_strobe #%0d got %0d exp %0d", i, lastStb, lat - 1);
      end
      checks++;
      if (strobes.size() !== n || outs.size() !== 8 + D + n) begin
        errors++;
        $display("FAIL rd_counts #%0d strobes %0d exp %0d sck %0d exp %0d",
                 i, strobes.size(), n, outs.size(), 8 + D + n);
      end
      h = {8'hEB, a};
      hbad = 0;
      for (int q = 0; q < outs.size(); q++) begin
        if (q < 8) begin
          if (outs[q] !== {1'b1, h[28 - 4 * q +: 4]}) hbad++;
        end else if (outs[q][4] !== 1'b0) hbad++;
      end
      checks++;
      if (hbad !== 0) begin
        errors++;
        $display("FAIL rd_header #%0d bad nibbles %0d exp 0", i, hbad);
      end
      sbad = 0;
      got = '0;
      for (int q = 0; q < strobes.size() && q < 8; q++) begin
        pn = 3'(2 * (q / 2) + ((q % 2 == 0) ? 1 : 0));
        es = {pn[0], pn[2:1], d[(q / 2) * 8 + ((q % 2 == 0) ? 4 : 0) +: 4]};
        if (strobes[q] !== es) sbad++;
        pn = {strobes[q][5:4], strobes[q][6]};
        got[int'(pn[2:1]) * 8 + (pn[0] ? 4 : 0) +: 4] = strobes[q][3:0];
      end
      checks++;
      if (sbad !== 0) begin
        errors++;
        $display("FAIL rd_strobes #%0d bad strobes %0d exp 0", i, sbad);
      end
      mask = (n == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * n)) - 32'h1);
      checks++;
      if (got !== (d & mask)) begin
        errors++;
        $display("FAIL rd_assembled #%0d got %h exp %h", i, got, d & mask);
      end
    end
  endtask

  task automatic test_write();
`ifdef QSPI_WRITE_EN
    logic [23:0] a;
    logic [31:0] d;
    logic [1:0]  t;
    logic [31:0] h;
    logic [4:0]  eo;
    int n;
    int bad;
    devSkip = 1000;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        a = 24'h80_0004; d = 32'hDEAD_BEEF; t = 2'b11;
      end else begin
        a = 24'($urandom); d = $urandom; t = 2'($urandom_range(1, 3));
      end
      n = nibs(t);
      xact(1'b1, a, t, d);
      checks++;
      if (lat !== 2 * (8 + n) + 1) begin
        errors++;
        $display("FAIL wr_latency #%0d got %0d exp %0d", i, lat, 2 * (8 + n) + 1);
      end
      checks++;
      if (strobes.size() !== 0 || outs.size() !== 8 + n) begin
        errors++;
        $display("FAIL wr_counts #%0d strobes %0d exp 0 sck %0d exp %0d",
                 i, strobes.size(), outs.size(), 8 + n);
      end
      h = {8'h38, a};
      bad = 0;
      for (int q = 0; q < outs.size() && q < 16; q++) begin
        if (q < 8) eo = {1'b1, h[28 - 4 * q +: 4]};
        else eo = {1'b1, d[((q - 8) / 2) * 8 + ((q % 2 == 0) ? 4 : 0) +: 4]};
        if (outs[q] !== eo) bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL wr_sequence #%0d bad nibbles %0d exp 0", i, bad);
      end
    end
`else
    for (int i = 0; i < 2; i++) begin
      xact(1'b1, 24'($urandom), 2'($urandom_range(1, 3)), $urandom);
      checks++;
      if (lat !== 1 || csLow !== 0 || outs.size() !== 0 || strobes.size() !== 0) begin
        errors++;
        $display("FAIL wr_disabled #%0d lat %0d exp 1 csLow %0d exp 0 sck %0d exp 0",
                 i, lat, csLow, outs.size());
      end
    end
`endif
  endtask

  task automatic test_noop();
    xact(1'b0, 24'($urandom), 2'b00, $urandom);
    checks++;
    if (lat !== 1 || csLow !== 0 || outs.size() !== 0 || strobes.size() !== 0) begin
      errors++;
      $display("FAIL noop lat %0d exp 1 csLow %0d exp 0 sck %0d exp 0",
               lat, csLow, outs.size());
    end
    @(posedge clk) #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL noop_recovery got ready %b exp 0", ready);
    end
    @(posedge clk) #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL noop_ready got ready %b exp 1", ready);
    end
  endtask

  task automatic test_back_to_back();
    int l1;
    int l2;
    int hi;
    for (int i = 0; i < 50 && !ready; i++) @(posedge clk) #1;
    devWord = $urandom;
    devSkip = 8 + D;
    req = 1'b1; wr = 1'b0; memType = 2'b11; spiAddrOut = 24'($urandom);
    @(posedge clk) #1;
    l1 = -1;
    hi = 0;
    for (int c = 1; c <= 300; c++) begin
      if (memReady) begin
        l1 = c;
        break;
      end
      if (cs_n) hi++;
      @(posedge clk) #1;
    end
    checks++;
    if (l1 !== 2 * (8 + D + 8) + 1 || hi !== 0) begin
      errors++;
      $display("FAIL b2b_first lat %0d exp %0d csHigh %0d exp 0", l1, 2 * (8 + D + 8) + 1, hi);
    end
    @(posedge clk) #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rec got ready %b exp 0", ready);
    end
    @(posedge clk) #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got ready %b exp 1", ready);
    end
    @(posedge clk) #1;
    checks++;
    if ({ready, cs_n} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_accept got ready,cs_n %b exp 00", {ready, cs_n});
    end
    req = 1'b0;
    l2 = -1;
    for (int c = 1; c <= 300; c++) begin
      if (memReady) begin
        l2 = c;
        break;
      end
      @(posedge clk) #1;
    end
    checks++;
    if (l2 !== 2 * (8 + D + 8) + 1) begin
      errors++;
      $display("FAIL b2b_second lat %0d exp %0d", l2, 2 * (8 + D + 8) + 1);
    end
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; wr = 1'b0; spiAddrOut = '0;
    memType = '0; wdata = '0; io_in = '0;
    devWord = '0; devSkip = 8 + D;
    test_reset();
    test_reads();
    test_write();
    test_noop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
